// File: rtl/rk_kbd_autotype_if.sv
// Scripted keystroke write port into the RK keyboard matrix.
// The master drives one key event; the slave accepts it with ev_ready.
interface rk_kbd_ev_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_row;
    logic [2:0] ev_col;
    logic       ev_press;

    modport master (output ev_valid, ev_row, ev_col, ev_press, input ev_ready);
    modport slave  (input ev_valid, ev_row, ev_col, ev_press, output ev_ready);
endinterface

// File: rtl/rk_kbd_autotype.sv
// RK keyboard autotype: plays a ROM keystroke script into the matrix after boot or download.
// Optional RK_AUTOTYPE_ABORT_EN: a live PS/2 event while busy aborts the running script.
module rk_kbd_autotype #(
    parameter int unsigned TICK_DIV   = 3000000,
    parameter int unsigned ENTRY_BOOT = 1,
    parameter int unsigned ENTRY_RUN  = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             boot_req_i,
    input  logic             dl_active_i,
    input  logic             live_evt_i,
    rk_kbd_ev_if.master      ev,
    output logic             kbd_clear_o,
    output logic             mod_clear_o,
    output logic             live_gate_o,
    output logic             busy_o,
    output logic [5:0]       pos_o
);

    localparam int unsigned DIV_W   = $clog2(TICK_DIV);
    localparam int unsigned POS_W   = 6;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned MAX_ROW = 10;
    localparam logic [7:0]  OP_STOP  = 8'hFF;
    localparam logic [7:0]  OP_DELAY = 8'h00;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_EMIT} state_e;

    // Script ROM: {press, col[2:0], row[3:0]}; 0x00 delay, 0xFF stop, unlisted indices stop.
    function automatic logic [7:0] rom_rd(input logic [POS_W-1:0] idx);
        case (idx)
            6'd1:  rom_rd = 8'hA6;  6'd2:  rom_rd = 8'h26;  // R
            6'd3:  rom_rd = 8'h82;  6'd4:  rom_rd = 8'h02;  // 0
            6'd5:  rom_rd = 8'hC3;  6'd6:  rom_rd = 8'h43;  // ,
            6'd7:  rom_rd = 8'h92;  6'd8:  rom_rd = 8'h12;  // 1
            6'd9:  rom_rd = 8'h82;  6'd10: rom_rd = 8'h02;  // 0
            6'd11: rom_rd = 8'hA1;  6'd12: rom_rd = 8'h21;  // CR
            6'd13, 6'd14, 6'd15, 6'd16,
            6'd17, 6'd18, 6'd19, 6'd20: rom_rd = OP_DELAY;
            6'd21: rom_rd = 8'hF4;  6'd22: rom_rd = 8'h74;  // G
            6'd23: rom_rd = 8'hA1;  6'd24: rom_rd = 8'h21;  // CR
            6'd26, 6'd27, 6'd28,
            6'd29, 6'd30, 6'd31: rom_rd = OP_DELAY;
            6'd32: rom_rd = 8'hF4;  6'd33: rom_rd = 8'h74;  // G
            6'd34: rom_rd = 8'hA1;  6'd35: rom_rd = 8'h21;  // CR
            default: rom_rd = OP_STOP;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             prev_boot_q, prev_dl_q;
    logic             ev_valid_q, ev_valid_d;
    logic [ROW_W-1:0] ev_row_q, ev_row_d;
    logic [COL_W-1:0] ev_col_q, ev_col_d;
    logic             ev_press_q, ev_press_d;
    logic             kbd_clear_q, kbd_clear_d;
    logic             mod_clear_q, mod_clear_d;

    logic       boot_fall, dl_fall, tick, is_delay;
    logic [7:0] rom_word;

    assign boot_fall = prev_boot_q & ~boot_req_i;
    assign dl_fall   = prev_dl_q & ~dl_active_i;
    assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
    assign rom_word  = rom_rd(pos_q);
    assign is_delay  = (rom_word == OP_DELAY) || (rom_word[3:0] > ROW_W'(MAX_ROW));

`ifndef RK_AUTOTYPE_ABORT_EN
    logic unused_live_evt;
    assign unused_live_evt = live_evt_i;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            div_q       <= '0;
            prev_boot_q <= 1'b0;
            prev_dl_q   <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_row_q    <= '0;
            ev_col_q    <= '0;
            ev_press_q  <= 1'b0;
            kbd_clear_q <= 1'b0;
            mod_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            div_q       <= div_d;
            prev_boot_q <= boot_req_i;
            prev_dl_q   <= dl_active_i;
            ev_valid_q  <= ev_valid_d;
            ev_row_q    <= ev_row_d;
            ev_col_q    <= ev_col_d;
            ev_press_q  <= ev_press_d;
            kbd_clear_q <= kbd_clear_d;
            mod_clear_q <= mod_clear_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        div_d       = div_q;
        ev_valid_d  = ev_valid_q;
        ev_row_d    = ev_row_q;
        ev_col_d    = ev_col_q;
        ev_press_d  = ev_press_q;
        kbd_clear_d = 1'b0;
        mod_clear_d = 1'b0;

        case (state_q)
            S_IDLE: div_d = '0;
            S_WAIT: begin
                if (tick) begin
                    div_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_FETCH: begin
                div_d = '0;
                if (rom_word == OP_STOP) begin
                    state_d = S_IDLE;
                end else if (is_delay) begin
                    pos_d   = pos_q + POS_W'(1);
                    state_d = S_WAIT;
                end else begin
                    ev_valid_d = 1'b1;
                    ev_press_d = rom_word[7];
                    ev_col_d   = rom_word[6:4];
                    ev_row_d   = rom_word[3:0];
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                div_d = '0;
                if (ev_valid_q && ev.ev_ready) begin
                    ev_valid_d  = 1'b0;
                    mod_clear_d = 1'b1;
                    pos_d       = pos_q + POS_W'(1);
                    state_d     = S_WAIT;
                end
            end
        endcase

`ifdef RK_AUTOTYPE_ABORT_EN
        if (live_evt_i && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            pos_d       = '0;
            div_d       = '0;
            ev_valid_d  = 1'b0;
            kbd_clear_d = 1'b1;
        end
`endif

        // A new trigger overrides everything, including an abort in the same cycle.
        if (boot_fall || dl_fall) begin
            pos_d       = boot_fall ? POS_W'(ENTRY_BOOT) : POS_W'(ENTRY_RUN);
            div_d       = '0;
            ev_valid_d  = 1'b0;
            kbd_clear_d = 1'b1;
            state_d     = S_WAIT;
        end
    end

    assign ev.ev_valid = ev_valid_q;
    assign ev.ev_row   = ev_row_q;
    assign ev.ev_col   = ev_col_q;
    assign ev.ev_press = ev_press_q;
    assign kbd_clear_o = kbd_clear_q;
    assign mod_clear_o = mod_clear_q;
    assign busy_o      = (state_q != S_IDLE);
    assign live_gate_o = (state_q == S_IDLE);
    assign pos_o       = pos_q;

endmodule

// File: tb/tb_rk_kbd_autotype.sv
// Directed bench for rk_kbd_autotype with TICK_DIV=4: event tables plus multi-cycle corner sequences.
module tb_rk_kbd_autotype;

    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       boot_req = 1'b0;
    logic       dl_active = 1'b0;
    logic       live_evt = 1'b0;
    logic       kbd_clear, mod_clear, live_gate, busy;
    logic [5:0] pos;

    rk_kbd_ev_if ev_bus ();

    rk_kbd_autotype #(
        .TICK_DIV  (TICK_DIV),
        .ENTRY_BOOT(1),
        .ENTRY_RUN (26)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .boot_req_i (boot_req),
        .dl_active_i(dl_active),
        .live_evt_i (live_evt),
        .ev         (ev_bus.master),
        .kbd_clear_o(kbd_clear),
        .mod_clear_o(mod_clear),
        .live_gate_o(live_gate),
        .busy_o     (busy),
        .pos_o      (pos)
    );

    always #5 clk = ~clk;

    // gap: cycles from the previous kbd_clear/mod_clear sample to this event's ev_valid
    typedef struct {
        logic [3:0] row;
        logic [2:0] col;
        logic       press;
        int         gap;
    } vec_t;

    vec_t vec [20];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input int r, input int c, input int p, input int g);
        vec[i].row   = 4'(r);
        vec[i].col   = 3'(c);
        vec[i].press = 1'(p);
        vec[i].gap   = g;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ev_bus.ev_valid && n < budget);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic check_ev(input string name, input int i);
        check(name, 32'({ev_bus.ev_row, ev_bus.ev_col, ev_bus.ev_press}),
              32'({vec[i].row, vec[i].col, vec[i].press}));
    endtask

    // Plays table entries lo..hi with ev_ready=1; skip trims cycles already spent before the call.
    task automatic play(input int lo, input int hi, input int skip);
        int n;
        for (int i = lo; i <= hi; i++) begin
            wait_valid(200, n);
            check("ev_gap", 32'(n), 32'((i == lo) ? vec[i].gap - skip : vec[i].gap));
            check_ev("ev_data", i);
            step();
            check("ev_accept", 32'({mod_clear, ev_bus.ev_valid}), 32'(2'b10));
        end
    endtask

    initial begin
        int n;

        // Boot script: R 0 , 1 0 CR, 8 delays, G CR
        set_vec(0, 6, 2, 1, 5);   set_vec(1, 6, 2, 0, 5);
        set_vec(2, 2, 0, 1, 5);   set_vec(3, 2, 0, 0, 5);
        set_vec(4, 3, 4, 1, 5);   set_vec(5, 3, 4, 0, 5);
        set_vec(6, 2, 1, 1, 5);   set_vec(7, 2, 1, 0, 5);
        set_vec(8, 2, 0, 1, 5);   set_vec(9, 2, 0, 0, 5);
        set_vec(10, 1, 2, 1, 5);  set_vec(11, 1, 2, 0, 5);
        set_vec(12, 4, 7, 1, 45); set_vec(13, 4, 7, 0, 5);
        set_vec(14, 1, 2, 1, 5);  set_vec(15, 1, 2, 0, 5);
        // Post-download script: 6 delays, G CR
        set_vec(16, 4, 7, 1, 35); set_vec(17, 4, 7, 0, 5);
        set_vec(18, 1, 2, 1, 5);  set_vec(19, 1, 2, 0, 5);

        ev_bus.ev_ready = 1'b1;

        // Reset values and a quiet idle period
        repeat (3) @(posedge clk);
        #1;
        check("reset_vals",
              32'({ev_bus.ev_valid, ev_bus.ev_row, ev_bus.ev_col, ev_bus.ev_press,
                   kbd_clear, mod_clear, busy, live_gate, pos}),
              32'({1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0}));
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_quiet", 32'({busy, kbd_clear, ev_bus.ev_valid, live_gate}), 32'(4'b0001));
        end
        check("idle_pos", 32'(pos), 32'(0));

        // Boot script end to end
        boot_req = 1'b1;
        step();
        boot_req = 1'b0;
        step();
        check("boot_trig", 32'({kbd_clear, busy, live_gate, pos}), 32'({1'b1, 1'b1, 1'b0, 6'd1}));
        play(0, 15, 0);
        wait_idle(50);
        check("boot_end", 32'({busy, live_gate, pos}), 32'({1'b0, 1'b1, 6'd25}));

        // Post-download script end to end
        dl_active = 1'b1;
        step();
        dl_active = 1'b0;
        step();
        check("dl_trig", 32'({kbd_clear, busy, pos}), 32'({1'b1, 1'b1, 6'd26}));
        play(16, 19, 0);
        wait_idle(50);
        check("dl_end", 32'({busy, pos}), 32'({1'b0, 6'd36}));

        // Back-pressure on the first boot event
        ev_bus.ev_ready = 1'b0;
        boot_req = 1'b1;
        step();
        boot_req = 1'b0;
        step();
        check("stall_trig", 32'({kbd_clear, pos}), 32'({1'b1, 6'd1}));
        wait_valid(20, n);
        check("stall_gap", 32'(n), 32'(5));
        check_ev("stall_first", 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_hold",
                  32'({ev_bus.ev_valid, ev_bus.ev_row, ev_bus.ev_col, ev_bus.ev_press, pos, mod_clear}),
                  32'({1'b1, 4'd6, 3'd2, 1'b1, 6'd1, 1'b0}));
        end
        ev_bus.ev_ready = 1'b1;
        step();
        check("stall_accept", 32'({mod_clear, ev_bus.ev_valid, pos}), 32'({1'b1, 1'b0, 6'd2}));
        wait_valid(20, n);
        check("stall_next_gap", 32'(n), 32'(TICK_DIV + 1));
        check_ev("stall_next", 1);
        step();
        check("stall_next_acc", 32'(mod_clear), 32'(1));

        // Download-end retrigger while a boot event is pending
        ev_bus.ev_ready = 1'b0;
        dl_active = 1'b1;
        wait_valid(20, n);
        check_ev("pend_ev", 2);
        check("pend_pos", 32'(pos), 32'(3));
        repeat (3) step();
        dl_active = 1'b0;
        step();
        check("retrig", 32'({kbd_clear, ev_bus.ev_valid, busy, pos}),
              32'({1'b1, 1'b0, 1'b1, 6'd26}));
        ev_bus.ev_ready = 1'b1;
        play(16, 19, 0);
        wait_idle(50);
        check("retrig_end", 32'(pos), 32'(36));

        // Simultaneous boot and download edges: boot wins
        boot_req = 1'b1;
        dl_active = 1'b1;
        step();
        boot_req = 1'b0;
        dl_active = 1'b0;
        step();
        check("both_trig", 32'({kbd_clear, pos}), 32'({1'b1, 6'd1}));
        wait_idle(400);
        check("both_end", 32'(pos), 32'(25));

`ifdef RK_AUTOTYPE_ABORT_EN
        // Live key aborts a script with an event pending
        ev_bus.ev_ready = 1'b0;
        dl_active = 1'b1;
        step();
        dl_active = 1'b0;
        step();
        wait_valid(100, n);
        check("abort_pend", 32'(ev_bus.ev_valid), 32'(1));
        live_evt = 1'b1;
        step();
        live_evt = 1'b0;
        check("abort", 32'({kbd_clear, busy, live_gate, pos, ev_bus.ev_valid}),
              32'({1'b1, 1'b0, 1'b1, 6'd0, 1'b0}));
        step();
        check("abort_after", 32'({kbd_clear, busy}), 32'(2'b00));
        ev_bus.ev_ready = 1'b1;
`else
        // Live key has no effect on a running script
        dl_active = 1'b1;
        step();
        dl_active = 1'b0;
        step();
        check("live_trig", 32'({kbd_clear, pos}), 32'({1'b1, 6'd26}));
        live_evt = 1'b1;
        step();
        live_evt = 1'b0;
        check("live_ignored", 32'({busy, kbd_clear}), 32'(2'b10));
        play(16, 19, 1);
        wait_idle(50);
        check("live_end", 32'(pos), 32'(36));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
